// File: rtl/shift_xfer_pkg.sv
// Shared types and helpers for the word-level shift transfer controller.
package shift_xfer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } xfer_state_e;

  // Bits needed to count 0..w-1 shifts; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_xfer_ctrl_sreg.sv
// Loadable parallel/serial shift register with a debug-step clock enable.
module shiftReg #(
  parameter int unsigned DEBUG     = 1,
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned MSB_IN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dbg_clk_enable,
  input  logic                 loadEn,
  input  logic                 shiftEn,
  input  logic                 serialIn,
  input  logic [REG_WIDTH-1:0] parallelIn,
  output logic                 serialOut,
  output logic [REG_WIDTH-1:0] parallelOut
);

  logic [REG_WIDTH-1:0] data_q, data_d;
  logic                 ce;

  assign ce = (DEBUG != 0) ? dbg_clk_enable : 1'b1;

  always_comb begin
    data_d = data_q;
    if (loadEn) begin
      data_d = parallelIn;
    end else if (shiftEn) begin
      data_d = (MSB_IN != 0) ? {serialIn, data_q[REG_WIDTH-1:1]}
                             : {data_q[REG_WIDTH-2:0], serialIn};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (ce) begin
      data_q <= data_d;
    end
  end

  assign serialOut   = (MSB_IN != 0) ? data_q[0] : data_q[REG_WIDTH-1];
  assign parallelOut = data_q;

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Sequences one shiftReg through load, REG_WIDTH serial exchanges and word hand-off.
module shift_xfer_ctrl
  import shift_xfer_pkg::*;
#(
  parameter int unsigned DEBUG     = 1,
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned MSB_IN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_data,
  output logic                 ser_out,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  input  logic                 ser_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] out_data,
  output logic                 busy,
  input  logic                 dbg_clk_enable
);

  localparam int unsigned CntW = cnt_width(REG_WIDTH);

  if (REG_WIDTH < 2) begin : gen_width_check
    $error("shift_xfer_ctrl: REG_WIDTH must be >= 2");
  end

  xfer_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ce;
  logic            load_en;
  logic            shift_en;

  assign ce = (DEBUG != 0) ? dbg_clk_enable : 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    out_valid = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = ~rst;
        if (in_valid && ~rst && ce) begin
          load_en = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        ser_valid = 1'b1;
        if (ser_ready && ce) begin
          shift_en = 1'b1;
          // Last bit: park the counter at zero so it never leaves 0..REG_WIDTH-1.
          if (cnt_q == CntW'(REG_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready && ce) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != StIdle);

  shiftReg #(
    .DEBUG    (DEBUG),
    .REG_WIDTH(REG_WIDTH),
    .MSB_IN   (MSB_IN)
  ) u_sreg (
    .clk           (clk),
    .rst           (rst),
    .dbg_clk_enable(ce),
    .loadEn        (load_en),
    .shiftEn       (shift_en),
    .serialIn      (ser_in),
    .parallelIn    (in_data),
    .serialOut     (ser_out),
    .parallelOut   (out_data)
  );

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Scoreboard bench: MSb-first and LSb-first instances driven in lockstep.
module tb_shift_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ser_ready;
  logic       ser_in0, ser_in1;
  logic       out_ready;
  logic       dbg_en;

  logic       in_ready0, ser_out0, ser_valid0, out_valid0, busy0;
  logic       in_ready1, ser_out1, ser_valid1, out_valid1, busy1;
  logic [7:0] out_data0, out_data1;

  int n_chk = 0;
  int n_err = 0;

  logic exp0_q[$];
  logic exp1_q[$];
  logic [7:0] word_q[$];

  always #5 clk = ~clk;

  shift_xfer_ctrl #(.DEBUG(1), .REG_WIDTH(8), .MSB_IN(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_ready(ser_ready), .ser_in(ser_in0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0),
    .dbg_clk_enable(dbg_en)
  );

  shift_xfer_ctrl #(.DEBUG(1), .REG_WIDTH(8), .MSB_IN(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_ready(ser_ready), .ser_in(ser_in1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1),
    .dbg_clk_enable(dbg_en)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_flags(input int ph, input logic r);
    chk("in_ready0", 32'(in_ready0), 32'(ph == 0 && !r));
    chk("in_ready1", 32'(in_ready1), 32'(ph == 0 && !r));
    chk("ser_valid0", 32'(ser_valid0), 32'(ph == 1));
    chk("ser_valid1", 32'(ser_valid1), 32'(ph == 1));
    chk("out_valid0", 32'(out_valid0), 32'(ph == 2));
    chk("out_valid1", 32'(out_valid1), 32'(ph == 2));
    chk("busy0", 32'(busy0), 32'(ph != 0));
    chk("busy1", 32'(busy1), 32'(ph != 0));
  endtask

  // One transfer; cycle 0 is the accept cycle. Ranges are inclusive, -1 disables.
  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] rx,
                         input int st_lo, input int st_hi, input int dg_lo, input int dg_hi,
                         input int hold, input int rst_at, input int exp_lat);
    int   c = 0;
    int   nbit = 0;
    int   hold_left = hold;
    int   ph = 0;
    int   lat = -1;
    bit   fin = 0;
    bit   aborted = 0;
    logic e0, e1;
    logic [7:0] w;
    while (!fin && c < 100) begin
      rst       = (c == rst_at);
      dbg_en    = !(c >= dg_lo && c <= dg_hi);
      in_valid  = 1'b1;
      in_data   = (ph == 0) ? tx : ~tx;
      ser_ready = !(c >= st_lo && c <= st_hi);
      ser_in0   = (nbit < 8) ? rx[7 - nbit] : 1'b0;
      ser_in1   = (nbit < 8) ? rx[nbit] : 1'b0;
      out_ready = (hold_left == 0);
      @(negedge clk);
      chk_flags(ph, rst);
      if (ph == 1 && exp0_q.size() > 0) begin
        chk("ser_out0", 32'(ser_out0), 32'(exp0_q[0]));
        chk("ser_out1", 32'(ser_out1), 32'(exp1_q[0]));
      end
      if (ph == 2 && word_q.size() > 0) begin
        chk("out_data0", 32'(out_data0), 32'(word_q[0]));
        chk("out_data1", 32'(out_data1), 32'(word_q[0]));
      end
      if (rst) begin
        ph = 0; aborted = 1; fin = 1;
        exp0_q.delete(); exp1_q.delete(); word_q.delete();
      end else begin
        case (ph)
          0: if (dbg_en) begin
            chk("accept_cycle", 32'(c), 32'd0);
            for (int i = 0; i < 8; i++) begin
              exp0_q.push_back(tx[7 - i]);
              exp1_q.push_back(tx[i]);
            end
            word_q.push_back(rx);
            ph = 1; nbit = 0;
          end
          1: if (dbg_en && ser_ready) begin
            if (exp0_q.size() == 0) chk("ser_q_empty", 32'd1, 32'd0);
            else begin
              e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
            end
            nbit++;
            if (nbit == 8) ph = 2;
          end
          2: begin
            if (lat < 0) begin
              lat = c;
              chk("latency", 32'(lat), 32'(exp_lat));
            end
            if (!out_ready) hold_left--;
            else if (dbg_en) begin
              if (word_q.size() == 0) chk("word_q_empty", 32'd1, 32'd0);
              else w = word_q.pop_front();
              ph = 0; fin = 1;
            end
          end
          default: ;
        endcase
      end
      @(posedge clk); #1;
      c++;
    end
    if (!fin) chk("xfer_timeout", 32'd1, 32'd0);
    if (aborted) begin
      rst = 1'b0; in_valid = 1'b0; dbg_en = 1'b1; ser_ready = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        chk_flags(0, 1'b0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; ser_ready = 1'b1;
    ser_in0 = 1'b0; ser_in1 = 1'b0; out_ready = 1'b1; dbg_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_in_ready0", 32'(in_ready0), 32'd0);
      chk("rst_in_ready1", 32'(in_ready1), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_flags(0, 1'b0);
      @(posedge clk); #1;
    end

    do_xfer(8'hA5, 8'h3C, -1, -1, -1, -1, 0, -1, 9);
    do_xfer(8'h5A, 8'hC3, 3, 5, -1, -1, 0, -1, 12);
    do_xfer(8'h96, 8'h69, -1, -1, -1, -1, 4, -1, 9);
    do_xfer(8'hFF, 8'h81, -1, -1, -1, -1, 0, -1, 9);
    do_xfer(8'h3C, 8'hA5, -1, -1, 4, 6, 0, -1, 12);
    do_xfer(8'h12, 8'hEE, -1, -1, -1, -1, 0, 4, 0);
    do_xfer(8'hC7, 8'h1D, -1, -1, -1, -1, 0, -1, 9);
    for (int t = 0; t < 4; t++) begin
      do_xfer(8'($urandom), 8'($urandom), 2 + t, 2 + t, -1, -1, t, -1, 10);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_xfer_ctrl.md
Name: shift_xfer_ctrl

Overview:
Word-level controller that sequences one internal shiftReg instance through a full bit-serial exchange.
- Accepts a parallel word on a valid/ready handshake and loads it.
- Shifts it out serially under a per-bit valid/ready handshake while capturing the incoming serial bits.
- Presents the captured word on an output valid/ready handshake.
- Sits between the vector-engine word datapath and a bit-serial link or PE chain.

Parameters:
DEBUG, 1, when 1 all state advances only while dbg_clk_enable=1; when 0 dbg_clk_enable is ignored
REG_WIDTH, 8, word width and number of shifts per transfer; must be >= 2 (assert)
MSB_IN, 0, passed to shiftReg; 0 = serial in at LSb / out at MSb (MSb-first), 1 = in at MSb / out at LSb (LSb-first)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  controller can accept a word
in_data  in  REG_WIDTH  word to transmit
ser_out  out  1  current serial bit (shiftReg serialOut)
ser_valid  out  1  ser_out is valid
ser_ready  in  1  link consumes ser_out and presents ser_in this cycle
ser_in  in  1  incoming serial bit, sampled on a ser_valid & ser_ready cycle
out_valid  out  1  captured word valid
out_ready  in  1  consumer accepts the captured word
out_data  out  REG_WIDTH  captured word (shiftReg parallelOut)
busy  out  1  state != IDLE
dbg_clk_enable  in  1  debug stepping clock enable

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst overrides dbg_clk_enable.
- Reset state: IDLE, bit counter = 0, in_ready=1, ser_valid=0, out_valid=0, busy=0. out_data content is don't-care while out_valid=0.
- ce = DEBUG ? dbg_clk_enable : 1. ce gates the FSM, the counter and the shiftReg dbg_clk_enable. The handshake outputs are combinational from state, so they hold while ce=0.
- IDLE:
  - in_ready = 1 (only in IDLE; rst low).
  - On in_valid & in_ready & ce: shiftReg loadEn=1, parallelIn=in_data, cnt<=0, next state SHIFT.
- SHIFT:
  - ser_valid = 1; ser_out = shiftReg serialOut.
  - On ser_valid & ser_ready & ce: shiftEn=1, serialIn=ser_in, cnt<=cnt+1.
  - When that happens with cnt == REG_WIDTH-1, next state DONE.
  - ser_ready=0 stalls: no shift, ser_out is stable.
- DONE:
  - out_valid = 1; out_data = parallelOut, which after REG_WIDTH shifts equals the captured bits.
  - On out_ready & ce: next state IDLE.
- Counter: width $clog2(REG_WIDTH); it never exceeds REG_WIDTH-1. No wrap is needed because it is cleared on load.
- Latency with no stalls: accept at cycle 0; bits on cycles 1..REG_WIDTH; out_valid at cycle REG_WIDTH+1. Each ser_ready=0 cycle adds 1.
- Back-to-back transfers: a new word is accepted in the cycle after the out handshake, in IDLE. There is no overlap, so loadEn and shiftEn are never both 1.
- rst mid-transfer: the next state is IDLE, the partial word is discarded, and out_valid is never asserted for it.
- in_valid outside IDLE is ignored. in_data must be held by the source only until the handshake.

Decomposition:
- Shared package shift_xfer_pkg:
  - state enum {IDLE, SHIFT, DONE} (2 bits);
  - function for counter width ($clog2-based).
- One sub-module: shiftReg (existing), instantiated as u_sreg.
  - Parameters passed: DEBUG, REG_WIDTH, MSB_IN.
  - dbg_clk_enable driven by ce.
- FSM, counter and handshake logic live in shift_xfer_ctrl.

Test Plan:
- rst high 2 cycles with in_valid=1 -> in_ready=0 during rst. After rst: in_ready=1, ser_valid=0, out_valid=0, busy=0, no word accepted.
- REG_WIDTH=8, MSB_IN=0, in_data=0xA5, ser_ready=1, ser_in MSb-first of 0x3C -> ser_out=1,0,1,0,0,1,0,1 on cycles 1..8; out_valid on cycle 9 with out_data=0x3C.
- Same as above, with MSB_IN=1 and ser_in LSb-first of 0x3C -> ser_out=1,0,1,0,0,1,0,1 (0xA5 LSb-first); out_data=0x3C.
- ser_ready=0 on cycles 3..5 -> ser_out and counter frozen; out_valid on cycle 12; out_data is still correct.
- out_ready=0 for 4 cycles in DONE -> out_valid and out_data held, in_ready=0. out_ready=1 -> IDLE next cycle; a second word 0xFF is accepted one cycle later.
- DEBUG=1, dbg_clk_enable=0 on cycles 4..6 of SHIFT -> state, counter and data frozen. Resumes correctly. Separately, rst at SHIFT cycle 4 -> IDLE next cycle, out_valid never asserted.
